// File: rtl/uart_mmio_pkg.sv
// Shared constants and types for the UART memory-mapped bridge.
package uart_mmio_pkg;

    localparam logic [31:0] TXD_ADDR = 32'h4000_0018;
    localparam logic [31:0] RXD_ADDR = 32'h4000_001C;
    localparam logic [31:0] CON_ADDR = 32'h4000_0020;

    localparam int TX_FIFO_DEPTH = 4;

    localparam int CON_TX_FULL  = 0;
    localparam int CON_RX_VALID = 1;
    localparam int CON_RX_OVR   = 2;
    localparam int CON_TX_IDLE  = 3;
    localparam int CON_IRQ_EN   = 4;

    localparam int TO_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WBUSY = 2'd2,
        ST_WDONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO buffering CPU writes ahead of the UART sender.
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               wdata,
    input  logic                     pop,
    output logic [7:0]               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    // A push on a full FIFO is dropped without touching any state.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_mmio_bridge.sv
// CPU-bus register front end for the UART: TX FIFO + pacing FSM, RX capture, IRQ.
module uart_mmio_bridge
    import uart_mmio_pkg::*;
#(
    parameter int DEPTH = TX_FIFO_DEPTH
) (
    input  logic        sysclk,
    input  logic        reset_n,
    input  logic [31:0] addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic [7:0]  tx_data,
    output logic        tx_enable,
    input  logic        tx_status,
    input  logic [7:0]  rx_data,
    input  logic        rx_status
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic            tx_s1_q, tx_s2_q;
    logic            rx_s1_q, rx_s2_q, rx_prev_q;
    tx_state_e       state_q, state_d;
    logic [TO_W-1:0] timer_q, timer_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_en_q, tx_en_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rx_ovr_q, rx_ovr_d;
    logic            irq_en_q, irq_en_d;

    logic            sel_txd, sel_rxd, sel_con;
    logic            push, pop, full, empty;
    logic [7:0]      head;
    logic [CW-1:0]   count;
    logic            rxd_pop, con_wr, rx_rise, tx_idle;
    logic [31:0]     con_val;
    logic            unused_bits;

    assign sel_txd = (addr == TXD_ADDR);
    assign sel_rxd = (addr == RXD_ADDR);
    assign sel_con = (addr == CON_ADDR);
    assign push    = mem_write & sel_txd;
    assign rxd_pop = mem_read & sel_rxd;
    assign con_wr  = mem_write & sel_con;
    assign rx_rise = rx_s2_q & ~rx_prev_q;
    assign tx_idle = empty & (state_q == ST_IDLE);

    assign irq       = rx_valid_q & irq_en_q;
    assign tx_data   = tx_data_q;
    assign tx_enable = tx_en_q;

    assign unused_bits = ^{wdata[31:8], count};

    uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (sysclk),
        .rst_n (reset_n),
        .push  (push),
        .wdata (wdata[7:0]),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // WBUSY gives up after 2048 cycles so a silent UART cannot wedge the FIFO.
    always_comb begin
        state_d   = state_q;
        timer_d   = '0;
        pop       = 1'b0;
        tx_data_d = tx_data_q;
        tx_en_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!empty && tx_s2_q) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                pop       = 1'b1;
                tx_data_d = head;
                tx_en_d   = 1'b1;
                state_d   = ST_WBUSY;
            end
            ST_WBUSY: begin
                timer_d = timer_q + TO_W'(1);
                if (!tx_s2_q) state_d = ST_WDONE;
                else if (timer_q == '1) state_d = ST_IDLE;
            end
            ST_WDONE: begin
                if (tx_s2_q) state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        rx_byte_d  = rx_rise ? rx_data : rx_byte_q;
        rx_valid_d = rx_rise | (rx_valid_q & ~rxd_pop);
        irq_en_d   = con_wr ? wdata[CON_IRQ_EN] : irq_en_q;
        rx_ovr_d   = rx_ovr_q;
        if (con_wr && wdata[CON_RX_OVR]) rx_ovr_d = 1'b0;
        if (rx_rise && rx_valid_q && !rxd_pop) rx_ovr_d = 1'b1;
    end

    always_comb begin
        con_val               = '0;
        con_val[CON_TX_FULL]  = full;
        con_val[CON_RX_VALID] = rx_valid_q;
        con_val[CON_RX_OVR]   = rx_ovr_q;
        con_val[CON_TX_IDLE]  = tx_idle;
        con_val[CON_IRQ_EN]   = irq_en_q;
    end

    always_comb begin
        unique case (1'b1)
            sel_rxd: rdata = {24'b0, rx_byte_q};
            sel_con: rdata = con_val;
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            tx_s1_q    <= 1'b1;
            tx_s2_q    <= 1'b1;
            rx_s1_q    <= 1'b0;
            rx_s2_q    <= 1'b0;
            rx_prev_q  <= 1'b0;
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            tx_data_q  <= '0;
            tx_en_q    <= 1'b0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            irq_en_q   <= 1'b0;
        end else begin
            tx_s1_q    <= tx_status;
            tx_s2_q    <= tx_s1_q;
            rx_s1_q    <= rx_status;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            state_q    <= state_d;
            timer_q    <= timer_d;
            tx_data_q  <= tx_data_d;
            tx_en_q    <= tx_en_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
            irq_en_q   <= irq_en_d;
        end
    end

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Directed bench for uart_mmio_bridge with a queue/flag model of the bridge.
module tb_uart_mmio_bridge;

    localparam logic [31:0] TXD = 32'h4000_0018;
    localparam logic [31:0] RXD = 32'h4000_001C;
    localparam logic [31:0] CON = 32'h4000_0020;

    logic        sysclk = 1'b0;
    logic        reset_n;
    logic [31:0] addr;
    logic        mem_read, mem_write;
    logic [31:0] wdata, rdata;
    logic        irq;
    logic [7:0]  tx_data;
    logic        tx_enable;
    logic        tx_status;
    logic [7:0]  rx_data;
    logic        rx_status;

    always #5 sysclk = ~sysclk;

    uart_mmio_bridge dut (
        .sysclk    (sysclk),
        .reset_n   (reset_n),
        .addr      (addr),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .wdata     (wdata),
        .rdata     (rdata),
        .irq       (irq),
        .tx_data   (tx_data),
        .tx_enable (tx_enable),
        .tx_status (tx_status),
        .rx_data   (rx_data),
        .rx_status (rx_status)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0] pend[$];
    bit         m_rx_valid = 0;
    bit         m_ovr = 0;
    bit         m_irq_en = 0;
    logic [7:0] m_rx_byte = 8'h00;
    bit         rx_stable = 1;
    bit         uart_stuck = 0;
    int         pulse_cnt = 0;
    int         pulse_cyc[$];
    int         cyc = 0;
    logic [7:0] last_tx = 8'h00;
    bit         prev_en = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model_con(input bit full, input bit idle);
        return {27'b0, m_irq_en, idle, m_ovr, m_rx_valid, full};
    endfunction

    always @(negedge sysclk) begin
        cyc++;
        if (!reset_n) begin
            chk("rst_tx_enable", 32'(tx_enable), 32'h0);
            chk("rst_tx_data", 32'(tx_data), 32'h0);
            chk("rst_irq", 32'(irq), 32'h0);
            last_tx = 8'h00;
            prev_en = 0;
        end else begin
            chk("tx_enable_one_cycle", 32'(tx_enable & prev_en), 32'h0);
            if (tx_enable) begin
                if (pend.size() == 0) begin
                    chk("tx_pulse_expected", 32'(pend.size()), 32'h1);
                end else begin
                    chk("tx_pulse_data", 32'(tx_data), 32'(pend.pop_front()));
                end
                last_tx = tx_data;
                pulse_cnt++;
                pulse_cyc.push_back(cyc);
            end else begin
                chk("tx_data_hold", 32'(tx_data), 32'(last_tx));
            end
            if (rx_stable) chk("irq_model", 32'(irq), 32'(m_rx_valid & m_irq_en));
            prev_en = tx_enable;
        end
    end

    // UART sender: drops tx_status for 100 cycles after each start pulse.
    initial begin
        forever begin
            @(negedge sysclk);
            if (tx_enable && !uart_stuck) begin
                @(posedge sysclk);
                #1 tx_status = 1'b0;
                repeat (100) @(posedge sysclk);
                #1 tx_status = 1'b1;
            end
        end
    end

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        wdata = d;
        mem_write = 1'b1;
        @(posedge sysclk);
        #1;
        mem_write = 1'b0;
        addr = '0;
        wdata = '0;
        if (a == TXD) begin
            if (pend.size() < 4) pend.push_back(d[7:0]);
        end else if (a == CON) begin
            m_irq_en = d[4];
            if (d[2]) m_ovr = 0;
        end
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        mem_read = 1'b1;
        @(negedge sysclk);
        d = rdata;
        @(posedge sysclk);
        #1;
        mem_read = 1'b0;
        addr = '0;
        if (a == RXD) m_rx_valid = 0;
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        rx_stable = 0;
        rx_data = b;
        rx_status = 1'b1;
        cyc_wait(16);
        rx_status = 1'b0;
        cyc_wait(4);
        if (m_rx_valid) m_ovr = 1;
        m_rx_valid = 1;
        m_rx_byte = b;
        rx_stable = 1;
    endtask

    task automatic check_con(input string nm, input bit full, input bit idle,
                             input logic [31:0] lit);
        logic [31:0] v;
        cpu_read(CON, v);
        chk({nm, "_model"}, v, model_con(full, idle));
        chk({nm, "_literal"}, v, lit);
    endtask

    task automatic wait_pulses(input int target, input int budget, input string nm);
        int n = 0;
        while (pulse_cnt < target && n < budget) begin
            @(posedge sysclk);
            n++;
        end
        #1;
        chk(nm, 32'(pulse_cnt), 32'(target));
    endtask

    initial begin
        logic [31:0] v;
        int gap;
        reset_n = 1'b0;
        addr = '0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        wdata = '0;
        tx_status = 1'b1;
        rx_data = 8'h00;
        rx_status = 1'b0;
        repeat (3) @(posedge sysclk);
        #1;
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;
        cyc_wait(2);
        check_con("con_after_reset", 0, 1, 32'h8);
        cpu_read(32'h4000_0000, v);
        chk("unmapped_read", v, 32'h0);
        cpu_read(TXD, v);
        chk("txd_read_zero", v, 32'h0);

        cpu_write(TXD, 32'h55);
        wait_pulses(1, 20, "t2_pulse");
        chk("t2_tx_data", 32'(tx_data), 32'h55);
        check_con("t2_busy", 0, 0, 32'h0);
        cyc_wait(120);
        check_con("t2_idle", 0, 1, 32'h8);

        cpu_write(TXD, 32'h10);
        wait_pulses(2, 20, "t3_lead_pulse");
        for (int i = 1; i <= 5; i++) cpu_write(TXD, 32'(i));
        check_con("t3_full", 1, 0, 32'h1);
        wait_pulses(6, 700, "t3_drain");
        cyc_wait(150);
        chk("t3_fifth_dropped", 32'(pulse_cnt), 32'd6);
        check_con("t3_idle", 0, 1, 32'h8);

        cpu_write(CON, 32'h10);
        rx_pulse(8'hA3);
        chk("t4_irq", 32'(irq), 32'h1);
        check_con("t4_rx", 0, 1, 32'h1A);
        cpu_read(RXD, v);
        chk("t4_rxd", v, 32'hA3);
        chk("t4_irq_clear", 32'(irq), 32'h0);
        check_con("t4_popped", 0, 1, 32'h18);

        rx_pulse(8'h11);
        rx_pulse(8'h22);
        check_con("t5_overrun", 0, 1, 32'h1E);
        cpu_read(RXD, v);
        chk("t5_rxd_second", v, {24'b0, m_rx_byte});
        chk("t5_rxd_literal", v, 32'h22);
        check_con("t5_after_read", 0, 1, 32'h1C);
        cpu_write(CON, 32'h14);
        check_con("t5_ovr_cleared", 0, 1, 32'h18);

        cpu_write(TXD, 32'h77);
        wait_pulses(7, 20, "t1_pulse");
        cpu_write(TXD, 32'h78);
        cpu_write(TXD, 32'h79);
        rx_pulse(8'h5A);
        chk("t1_irq_before", 32'(irq), 32'h1);
        reset_n = 1'b0;
        pend.delete();
        m_rx_valid = 0;
        m_ovr = 0;
        m_irq_en = 0;
        cyc_wait(2);
        chk("t1_irq", 32'(irq), 32'h0);
        chk("t1_tx_enable", 32'(tx_enable), 32'h0);
        chk("t1_tx_data", 32'(tx_data), 32'h0);
        check_con("t1_con_in_reset", 0, 1, 32'h8);
        reset_n = 1'b1;
        cyc_wait(300);
        chk("t1_no_retransmit", 32'(pulse_cnt), 32'd7);
        check_con("t1_con_after", 0, 1, 32'h8);

        uart_stuck = 1;
        cpu_write(TXD, 32'hC1);
        cpu_write(TXD, 32'hC2);
        wait_pulses(8, 20, "t6_first");
        wait_pulses(9, 2200, "t6_after_timeout");
        if (pulse_cyc.size() >= 2) begin
            gap = pulse_cyc[$] - pulse_cyc[$-1];
            checks++;
            if (gap < 2048 || gap > 2056) begin
                failures++;
                $display("FAIL t6_timeout_gap: got %0d cycles expected 2048..2056", gap);
            end
        end
        cyc_wait(2100);
        chk("t6_pulse_total", 32'(pulse_cnt), 32'd9);
        check_con("t6_idle", 0, 1, 32'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
